output_arbiter: RTL and testbench
=================================

# output_arbiter

Packet-level round-robin arbiter that drives the 4-bit select of a router's 10:1 32-bit output multiplexer. It sits beside each output port of the BiNoC router. Ten requesters share the port: input ports × virtual channels, requester index i equals mux input i. A granted requester holds the port from its head flit through its tail flit, after which priority rotates.

## Interface
Parameters:
- NUM_REQ, 10: number of requesters; must equal mux input count.
- SEL_W, 4: select width, ceil(log2(NUM_REQ)).
- MAX_FLITS, 16: flits allowed per packet before the watchdog forces release; minimum 2.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- req, input, NUM_REQ: req[i]=1 means requester i has a flit ready on mux input i.
- tail, input, NUM_REQ: tail[i]=1 means the flit presented by requester i is the packet's tail; meaningful only with req[i].
- out_ready, input, 1: downstream (link or credit) can accept a flit this cycle.
- sel, output, SEL_W: mux select, registered; equals index of current grant.
- grant, output, NUM_REQ: one-hot grant, registered; all-zero when idle.
- out_valid, output, 1: combinational, equals req[sel] while BUSY, else 0.
- xfer, output, 1: combinational, equals out_valid & out_ready; one flit moves this cycle.
- wd_err, output, 1: registered one-cycle pulse when the watchdog forces release.

## Operation
- State machine with two states: IDLE and BUSY.
- IDLE:
  - If req is nonzero, pick the first set bit at or above rr_ptr, wrapping from NUM_REQ-1 to 0.
  - Register grant (one-hot), sel (index) and flit count 0, then go to BUSY.
  - If req is zero, stay in IDLE; grant=0 and sel holds its last value.
- BUSY, granted index g:
  - Each xfer increments the flit count.
  - Release condition: xfer with tail[g]=1, or xfer when the count reaches MAX_FLITS-1 (watchdog).
  - On release: grant→0, rr_ptr→(g+1) mod NUM_REQ, go to IDLE.
  - On a watchdog release, additionally pulse wd_err for one cycle.
- A granted requester dropping req mid-packet does not release the lock; the arbiter stalls with out_valid=0 until req returns.
- Requests from other requesters are ignored while BUSY.
- Single-flit packet (head = tail) releases on its first xfer.
- sel never exceeds NUM_REQ-1. rr_ptr wraps with an explicit compare, not a power-of-2 modulo.
- Reset mid-packet: all state returns to reset values immediately. The partially sent packet is abandoned; upstream recovery is outside this block.

## Timing
Reset values: state=IDLE, grant=0, sel=0, rr_ptr=0, flit count=0, wd_err=0, out_valid=0, xfer=0.

Latency:
- Arbitration takes 1 cycle: req seen in IDLE at cycle N gives grant/sel valid at N+1.
- The first xfer can occur at N+1.
- The release xfer at cycle M gives IDLE at M+1; the next grant is valid at M+2.
- This leaves one bubble cycle between packets, by design.

Handshake:
- A flit transfers only when out_valid & out_ready.
- The requester must hold the flit stable until its xfer.
- sel and grant change only on clock edges, never mid-cycle.

Simultaneous events:
- tail xfer and watchdog limit on the same xfer: treated as a normal release, wd_err=0.
- A new req arriving on the same cycle as a release is arbitrated in the following IDLE cycle using the updated rr_ptr.

## Test plan
- Reset: hold rst_n=0 with req=10'h3FF. Require grant=0, sel=0, out_valid=0. Release reset; grant=10'h001, sel=0 one cycle later.
- Single requester, 3-flit packet: req[5]=1, tail on the 3rd flit, out_ready=1. Require sel=5 for 3 xfer cycles, then grant=0 the next cycle, and rr_ptr=6 (verified by the next arbitration order).
- Rotation with wrap: req[9] and req[2] both steady, single-flit packets. Require grant order 2, 9, 2, 9 starting from rr_ptr=0, with one idle cycle between grants.
- Backpressure and req drop: granted requester 4 with out_ready=0 for 5 cycles, then req[4]=0 for 2 cycles. Require xfer=0, sel stays 4, and the lock holds. The packet completes after resume.
- Watchdog: MAX_FLITS=16, requester 7 sends 16 flits with no tail. Require release on the 16th xfer, a wd_err pulse of 1 cycle, and rr_ptr=8.
- Mid-packet reset: assert rst_n=0 during flit 2 of a 4-flit packet from requester 3. Require all outputs back at reset values asynchronously, and a fresh arbitration from rr_ptr=0 after reset.

Source files
------------

// File: rtl/output_arbiter.sv
// Packet-level round-robin arbiter driving the select of a router output multiplexer.
// A granted requester owns the port from head through tail flit; a flit watchdog bounds the lock.
module output_arbiter #(
    parameter int NUM_REQ   = 10,
    parameter int SEL_W     = 4,
    parameter int MAX_FLITS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] tail,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] grant,
    output logic               out_valid,
    output logic               xfer,
    output logic               wd_err
);

    localparam int CNT_W = (MAX_FLITS > 2) ? $clog2(MAX_FLITS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wd_err_q, wd_err_d;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic [SEL_W-1:0]   next_ptr;
    logic               cur_req;
    logic               cur_tail;
    logic               at_limit;
    logic               release_now;

    // Scan offsets from highest to lowest so the nearest set bit at or above rr_ptr wins.
    always_comb begin
        logic [SEL_W:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
            if (cand >= (SEL_W+1)'(NUM_REQ)) begin
                cand = cand - (SEL_W+1)'(NUM_REQ);
            end
            if (req[cand[SEL_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[SEL_W-1:0];
            end
        end
    end

    assign cur_req  = req[sel_q];
    assign cur_tail = tail[sel_q];
    assign at_limit = (cnt_q == CNT_W'(MAX_FLITS - 1));
    assign next_ptr = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + SEL_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found)  state_d = BUSY;
            BUSY:    if (release_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid   = 1'b0;
        xfer        = 1'b0;
        release_now = 1'b0;
        if (state_q == BUSY) begin
            out_valid   = cur_req;
            xfer        = cur_req & out_ready;
            release_now = cur_req & out_ready & (cur_tail | at_limit);
        end
    end

    always_comb begin
        grant_d  = grant_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        wd_err_d = 1'b0;
        if (state_q == IDLE) begin
            if (pick_found) begin
                grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                sel_d   = pick_idx;
                cnt_d   = '0;
            end
        end else if (release_now) begin
            grant_d  = '0;
            rr_ptr_d = next_ptr;
            // A tail on the limit flit is an ordinary release.
            wd_err_d = ~cur_tail;
        end else if (xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q  <= '0;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            wd_err_q <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign sel    = sel_q;
    assign grant  = grant_q;
    assign wd_err = wd_err_q;

endmodule

// File: tb/tb_output_arbiter.sv
// Self-checking bench for output_arbiter: directed vector table, hand sequences for
// multi-cycle corners, then random traffic against a packet-level reference model.
module tb_output_arbiter;

    localparam int NUM_REQ   = 10;
    localparam int SEL_W     = 4;
    localparam int MAX_FLITS = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] tail;
    logic               out_ready;
    logic [SEL_W-1:0]   sel;
    logic [NUM_REQ-1:0] grant;
    logic               out_valid;
    logic               xfer;
    logic               wd_err;

    output_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .SEL_W    (SEL_W),
        .MAX_FLITS(MAX_FLITS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .tail     (tail),
        .out_ready(out_ready),
        .sel      (sel),
        .grant    (grant),
        .out_valid(out_valid),
        .xfer     (xfer),
        .wd_err   (wd_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: owner of the port, flits sent so far, next round-robin start.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_sent  = 0;
    int m_ptr   = 0;
    int m_sel   = 0;
    bit m_wd    = 1'b0;

    // Apply one cycle of inputs at the falling edge, compare against the model,
    // then advance the model to what the next rising edge should produce.
    task automatic drive(input logic r, input logic [NUM_REQ-1:0] rq,
                         input logic [NUM_REQ-1:0] tl, input logic rdy);
        logic [NUM_REQ-1:0] e_grant;
        bit e_valid, e_xfer, nw;
        @(negedge clk);
        rst_n     = r;
        req       = rq;
        tail      = tl;
        out_ready = rdy;
        #1;
        if (!r) begin
            m_busy = 1'b0; m_sel = 0; m_ptr = 0; m_sent = 0; m_wd = 1'b0;
        end
        e_grant = '0;
        if (m_busy) e_grant[m_owner] = 1'b1;
        e_valid = m_busy && rq[m_owner];
        e_xfer  = e_valid && rdy;
        check("m_grant", 32'(grant), 32'(e_grant));
        check("m_sel", 32'(sel), 32'(m_sel));
        check("m_valid", 32'(out_valid), 32'(e_valid));
        check("m_xfer", 32'(xfer), 32'(e_xfer));
        check("m_wd_err", 32'(wd_err), 32'(m_wd));
        if (r) begin
            nw = 1'b0;
            if (!m_busy) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    int c;
                    c = (m_ptr + k) % NUM_REQ;
                    if (rq[c]) begin
                        m_busy = 1'b1; m_owner = c; m_sel = c; m_sent = 0;
                        break;
                    end
                end
            end else if (e_xfer) begin
                m_sent++;
                if (tl[m_owner] || m_sent == MAX_FLITS) begin
                    nw     = !tl[m_owner];
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % NUM_REQ;
                end
            end
            m_wd = nw;
        end
    endtask

    task automatic expect_out(input string name, input logic [NUM_REQ-1:0] g,
                              input int s, input logic v, input logic x, input logic w);
        check({name, "_grant"}, 32'(grant), 32'(g));
        check({name, "_sel"}, 32'(sel), 32'(s));
        check({name, "_valid"}, 32'(out_valid), 32'(v));
        check({name, "_xfer"}, 32'(xfer), 32'(x));
        check({name, "_wd"}, 32'(wd_err), 32'(w));
    endtask

    typedef struct {
        logic               r;
        logic [NUM_REQ-1:0] rq;
        logic [NUM_REQ-1:0] tl;
        logic               rdy;
        logic [NUM_REQ-1:0] g;
        int                 s;
        logic               v;
        logic               x;
        logic               w;
    } vec_t;

    vec_t vecs[20];

    initial begin
        rst_n = 1'b0; req = '0; tail = '0; out_ready = 1'b0;

        // Reset with everyone requesting, then grant 0 right after release.
        vecs[0]  = '{1'b0, 10'h3FF, 10'h000, 1'b0, 10'h000, 0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 10'h3FF, 10'h000, 1'b0, 10'h000, 0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 10'h3FF, 10'h000, 1'b0, 10'h000, 0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 10'h001, 10'h001, 1'b0, 10'h001, 0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 10'h001, 10'h001, 1'b1, 10'h001, 0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 10'h000, 10'h000, 1'b1, 10'h000, 0, 1'b0, 1'b0, 1'b0};
        // Requester 5, three flits, tail on the third.
        vecs[6]  = '{1'b1, 10'h020, 10'h000, 1'b1, 10'h000, 0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 10'h020, 10'h000, 1'b1, 10'h020, 5, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 10'h020, 10'h000, 1'b1, 10'h020, 5, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 10'h020, 10'h020, 1'b1, 10'h020, 5, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 10'h000, 10'h000, 1'b1, 10'h000, 5, 1'b0, 1'b0, 1'b0};
        // Requesters 9 and 2, single-flit: from pointer 6 expect 9, then wrap to 2,9,2,9.
        vecs[11] = '{1'b1, 10'h204, 10'h204, 1'b1, 10'h000, 5, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 10'h204, 10'h204, 1'b1, 10'h200, 9, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 10'h204, 10'h204, 1'b1, 10'h000, 9, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 10'h204, 10'h204, 1'b1, 10'h004, 2, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 10'h204, 10'h204, 1'b1, 10'h000, 2, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 10'h204, 10'h204, 1'b1, 10'h200, 9, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 10'h204, 10'h204, 1'b1, 10'h000, 9, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 10'h204, 10'h204, 1'b1, 10'h004, 2, 1'b1, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 10'h000, 10'h000, 1'b1, 10'h000, 2, 1'b0, 1'b0, 1'b0};

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].rq, vecs[i].tl, vecs[i].rdy);
            expect_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].s,
                       vecs[i].v, vecs[i].x, vecs[i].w);
        end

        // Backpressure then request drop on requester 4 (pointer is 3 here).
        drive(1'b1, 10'h010, 10'h000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 10'h010, 10'h000, 1'b0);
            expect_out("bp_stall", 10'h010, 4, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 10'h3EF, 10'h000, 1'b1);
            expect_out("bp_drop", 10'h010, 4, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b1, 10'h010, 10'h000, 1'b1);
        expect_out("bp_flit1", 10'h010, 4, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 10'h010, 10'h010, 1'b1);
        expect_out("bp_tail", 10'h010, 4, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 10'h000, 10'h000, 1'b1);
        expect_out("bp_idle", 10'h000, 4, 1'b0, 1'b0, 1'b0);

        // Watchdog: requester 7 streams with no tail; release on the 16th xfer.
        drive(1'b1, 10'h080, 10'h000, 1'b1);
        for (int i = 1; i <= MAX_FLITS; i++) begin
            drive(1'b1, 10'h080, 10'h000, 1'b1);
            expect_out($sformatf("wd_flit%0d", i), 10'h080, 7, 1'b1, 1'b1, 1'b0);
        end
        drive(1'b1, 10'h101, 10'h101, 1'b1);
        expect_out("wd_pulse", 10'h000, 7, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 10'h101, 10'h101, 1'b1);
        expect_out("wd_ptr8", 10'h100, 8, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 10'h000, 10'h000, 1'b1);
        expect_out("wd_after", 10'h000, 8, 1'b0, 1'b0, 1'b0);

        // Mid-packet reset from requester 3 (pointer 9 wraps to pick 3).
        drive(1'b1, 10'h008, 10'h000, 1'b1);
        drive(1'b1, 10'h008, 10'h000, 1'b1);
        expect_out("mr_flit1", 10'h008, 3, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 10'h008, 10'h000, 1'b1);
        expect_out("mr_async", 10'h000, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 10'h208, 10'h000, 1'b1);
        expect_out("mr_released", 10'h000, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 10'h208, 10'h008, 1'b1);
        expect_out("mr_fresh", 10'h008, 3, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 10'h000, 10'h000, 1'b1);

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            logic r;
            r = ($urandom_range(0, 399) != 0);
            drive(r, NUM_REQ'($urandom & $urandom),
                  NUM_REQ'($urandom & $urandom & $urandom),
                  ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
